// File: rtl/adpcm_main_mul_arb.sv
// Two-requester arbitrated signed x unsigned multiplier with a 2-stage pipeline and a shared result.
// Define ADPCM_MUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); otherwise round-robin.
module adpcm_main_mul_arb #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 44
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [DIN0_WIDTH-1:0] req0_a,
    input  logic [DIN0_WIDTH-1:0] req1_a,
    input  logic [DIN1_WIDTH-1:0] req0_b,
    input  logic [DIN1_WIDTH-1:0] req1_b,
    output logic                  res0_valid,
    output logic                  res1_valid,
    output logic [DOUT_WIDTH-1:0] res_dout,
    output logic                  busy
);

    logic                  accept;
    logic                  win0;
    logic [DIN0_WIDTH-1:0] sel_a;
    logic [DIN1_WIDTH-1:0] sel_b;

    logic                  s1_valid;
    logic                  s1_tag;
    logic [DIN0_WIDTH-1:0] s1_a;
    logic [DIN1_WIDTH-1:0] s1_b;

    logic                  s2_valid;
    logic                  s2_tag;
    logic [DOUT_WIDTH-1:0] s2_dout;

    logic signed [DOUT_WIDTH-1:0] a_ext;
    logic signed [DOUT_WIDTH-1:0] b_ext;
    logic signed [DOUT_WIDTH-1:0] prod;

`ifdef ADPCM_MUL_ARB_FIXED_PRIO_EN
    assign win0 = 1'b1;
`else
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_t;

    last_t last_q;
    last_t last_d;

    // Reset value LAST_REQ1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= LAST_REQ1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (ce) begin
            if (req0_ready) begin
                last_d = LAST_REQ0;
            end else if (req1_ready) begin
                last_d = LAST_REQ1;
            end
        end
    end

    assign win0 = (last_q == LAST_REQ1);
`endif

    always_comb begin
        req0_ready = ce & ~reset & req0_valid & (~req1_valid | win0);
        req1_ready = ce & ~reset & req1_valid & (~req0_valid | ~win0);
    end

    assign accept = req0_ready | req1_ready;
    assign sel_a  = req1_ready ? req1_a : req0_a;
    assign sel_b  = req1_ready ? req1_b : req0_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (ce) begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag <= req1_ready;
                s1_a   <= sel_a;
                s1_b   <= sel_b;
            end
        end
    end

    // Operands are pre-extended to the full product width so the wrapped product is exact.
    always_comb begin
        a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){s1_a[DIN0_WIDTH-1]}}, s1_a};
        b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){1'b0}}, s1_b};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_dout  <= '0;
        end else if (ce) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag  <= s1_tag;
                s2_dout <= prod;
            end
        end
    end

    assign res0_valid = s2_valid & ~s2_tag;
    assign res1_valid = s2_valid & s2_tag;
    assign res_dout   = s2_dout;
    assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_adpcm_main_mul_arb.sv
// Scoreboard bench for adpcm_main_mul_arb: directed vectors push hand-computed results,
// a negedge monitor pops and compares each presented result.
module tb_adpcm_main_mul_arb;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req1_a;
    logic [11:0] req0_b, req1_b;
    logic        res0_valid, res1_valid;
    logic [43:0] res_dout;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [44:0] exp_q[$];
    logic edge_ok = 1'b0;

    adpcm_main_mul_arb #(
        .DIN0_WIDTH(32),
        .DIN1_WIDTH(12),
        .DOUT_WIDTH(44)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .req0_a    (req0_a),
        .req1_a    (req1_a),
        .req0_b    (req0_b),
        .req1_b    (req1_b),
        .res0_valid(res0_valid),
        .res1_valid(res1_valid),
        .res_dout  (res_dout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edge_ok <= ce && !reset;

    always @(negedge clk) begin
        logic [44:0] e;
        if (edge_ok && !reset) begin
            if (res0_valid && res1_valid) begin
                chk("res_both_valid", 64'(1'b1), 64'(1'b0));
            end else if (res0_valid || res1_valid) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 64'(res1_valid), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    chk("res_tag", 64'(res1_valid), 64'(e[44]));
                    chk("res_dout", 64'(res_dout), 64'(e[43:0]));
                end
            end
        end
    end

    task automatic cyc(input logic c,
                       input logic v0, input logic [31:0] a0, input logic [11:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [11:0] b1,
                       input logic er0, input logic er1,
                       input logic [43:0] e0, input logic [43:0] e1,
                       input string name);
        @(negedge clk);
        reset = 1'b0;
        ce = c;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        chk({name, "_ready0"}, 64'(req0_ready), 64'(er0));
        chk({name, "_ready1"}, 64'(req1_ready), 64'(er1));
        if (er0) exp_q.push_back({1'b0, e0});
        if (er1) exp_q.push_back({1'b1, e1});
    endtask

    task automatic idle(input string name);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, name);
    endtask

    // Round-robin tie operands: req0 7*2=14, req1 -5*10=-50.
    localparam logic [31:0] RA0 = 32'd7;
    localparam logic [11:0] RB0 = 12'd2;
    localparam logic [43:0] RP0 = 44'h0000000000E;
    localparam logic [31:0] RA1 = 32'hFFFFFFFB;
    localparam logic [11:0] RB1 = 12'd10;
    localparam logic [43:0] RP1 = 44'hFFFFFFFFFCE;

    initial begin
        reset = 1'b1; ce = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 12'd1; req1_a = 32'd1; req1_b = 12'd1;
        #2;
        chk("rst_ready0", 64'(req0_ready), 64'(1'b0));
        chk("rst_ready1", 64'(req1_ready), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_res0", 64'(res0_valid), 64'(1'b0));
        chk("rst_res1", 64'(res1_valid), 64'(1'b0));
        chk("rst_dout", 64'(res_dout), 64'(44'h0));

        // Signed/unsigned boundary products
        cyc(1, 1, 32'hFFFFFFFD, 12'hFFF, 0, '0, '0, 1, 0, 44'hFFFFFFFD003, '0, "neg3");
        cyc(1, 0, '0, '0, 1, 32'h7FFFFFFF, 12'hFFF, 0, 1, '0, 44'h7FF7FFFF001, "maxpos");
        cyc(1, 0, '0, '0, 1, 32'h80000000, 12'hFFF, 0, 1, '0, 44'h80080000000, "maxneg");

        // Continuous tie for 4 cycles
`ifdef ADPCM_MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            cyc(1, 1, RA0, RB0, 1, RA1, RB1, 1, 0, RP0, RP1, "tie");
`else
        for (int i = 0; i < 4; i++)
            cyc(1, 1, RA0, RB0, 1, RA1, RB1, (i % 2) == 0, (i % 2) == 1, RP0, RP1, "tie");
`endif
        idle("drain0");
        idle("drain1");
        idle("drain2");

        // ce freeze: A=100*10 reaches stage 2, B=-2*4095 waits in stage 1
        cyc(1, 1, 32'd100, 12'd10, 0, '0, '0, 1, 0, 44'h000000003E8, '0, "frzA");
        cyc(1, 1, 32'hFFFFFFFE, 12'hFFF, 0, '0, '0, 1, 0, 44'hFFFFFFFE002, '0, "frzB");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'd9, 12'd9, 0, '0, '0, 0, 0, '0, '0, "frz");
            chk("frz_res0", 64'(res0_valid), 64'(1'b1));
            chk("frz_dout", 64'(res_dout), 64'(44'h000000003E8));
        end
        idle("frz_rel0");
        idle("frz_rel1");
        @(negedge clk); #1;
        chk("hold_res0", 64'(res0_valid), 64'(1'b0));
        chk("hold_dout", 64'(res_dout), 64'(44'hFFFFFFFE002));
        chk("hold_busy", 64'(busy), 64'(1'b0));

        // Reset pulse right after an accept
        cyc(1, 1, 32'd3, 12'd3, 0, '0, '0, 1, 0, 44'h00000000009, '0, "rstop");
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_res0", 64'(res0_valid), 64'(1'b0));
        chk("midrst_res1", 64'(res1_valid), 64'(1'b0));
        chk("midrst_dout", 64'(res_dout), 64'(44'h0));
        chk("midrst_ready0", 64'(req0_ready), 64'(1'b0));
        chk("midrst_ready1", 64'(req1_ready), 64'(1'b0));
        cyc(1, 1, RA0, RB0, 1, RA1, RB1, 1, 0, RP0, RP1, "posttie");
        idle("end0");
        idle("end1");
        idle("end2");
        @(negedge clk); #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("end_busy", 64'(busy), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
